// File: rtl/com_bus_arbiter.sv
// Coherence-bus arbiter: round-robin processor ownership, fixed-priority snoop
// data supply within a tenure, and lower-level memory fallback.
module com_bus_arbiter #(
  parameter int NUM_PROC = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PROC-1:0] Com_Bus_Req_proc,
  input  logic [NUM_PROC-1:0] Com_Bus_Req_snoop,
  input  logic                Mem_snoop_req,
  output logic [NUM_PROC-1:0] Com_Bus_Gnt_proc,
  output logic [NUM_PROC-1:0] Com_Bus_Gnt_snoop,
  output logic                Mem_snoop_gnt,
  output logic                Bus_busy
);
  localparam int PW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam logic [NUM_PROC-1:0] ONE = NUM_PROC'(1);

  typedef enum logic {IDLE, PROC_OWN} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_PROC-1:0] gnt_proc_q, gnt_proc_d;
  logic [NUM_PROC-1:0] gnt_snoop_q, gnt_snoop_d;
  logic                mem_gnt_q, mem_gnt_d;
  logic                busy_q;

  logic                rr_hit, sn_hit, owner_req;
  logic [PW-1:0]       rr_win, sn_win;
  logic [NUM_PROC-1:0] sn_req;

  // Round-robin scan starting at rr_ptr, wrapping at NUM_PROC-1 -> 0.
  always_comb begin
    rr_hit = 1'b0;
    rr_win = '0;
    for (int k = 0; k < NUM_PROC; k++) begin
      if (!rr_hit && Com_Bus_Req_proc[(int'(rr_ptr_q) + k) % NUM_PROC]) begin
        rr_hit = 1'b1;
        rr_win = PW'((int'(rr_ptr_q) + k) % NUM_PROC);
      end
    end
  end

  // Owner cannot supply its own miss data, so its snoop bit is masked.
  assign sn_req    = Com_Bus_Req_snoop & ~gnt_proc_q;
  assign owner_req = |(Com_Bus_Req_proc & gnt_proc_q);

  always_comb begin
    sn_hit = 1'b0;
    sn_win = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (!sn_hit && sn_req[i]) begin
        sn_hit = 1'b1;
        sn_win = PW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_proc_d  = gnt_proc_q;
    gnt_snoop_d = gnt_snoop_q;
    mem_gnt_d   = mem_gnt_q;
    case (state_q)
      IDLE: begin
        gnt_proc_d  = '0;
        gnt_snoop_d = '0;
        mem_gnt_d   = 1'b0;
        if (rr_hit) begin
          gnt_proc_d = ONE << rr_win;
          rr_ptr_d   = PW'((int'(rr_win) + 1) % NUM_PROC);
          state_d    = PROC_OWN;
        end
      end
      PROC_OWN: begin
        if (!owner_req) begin
          gnt_proc_d  = '0;
          gnt_snoop_d = '0;
          mem_gnt_d   = 1'b0;
          state_d     = IDLE;
        end else if (|gnt_snoop_q) begin
          // A releasing supplier leaves the bus idle for one edge before re-arbitration.
          if (!(|(gnt_snoop_q & Com_Bus_Req_snoop))) gnt_snoop_d = '0;
        end else if (mem_gnt_q) begin
          if (!Mem_snoop_req) mem_gnt_d = 1'b0;
        end else if (sn_hit) begin
          gnt_snoop_d = ONE << sn_win;
        end else if (Mem_snoop_req) begin
          mem_gnt_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_proc_d  = '0;
        gnt_snoop_d = '0;
        mem_gnt_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_proc_q  <= '0;
      gnt_snoop_q <= '0;
      mem_gnt_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_proc_q  <= gnt_proc_d;
      gnt_snoop_q <= gnt_snoop_d;
      mem_gnt_q   <= mem_gnt_d;
      busy_q      <= |gnt_proc_d;
    end
  end

  assign Com_Bus_Gnt_proc  = gnt_proc_q;
  assign Com_Bus_Gnt_snoop = gnt_snoop_q;
  assign Mem_snoop_gnt     = mem_gnt_q;
  assign Bus_busy          = busy_q;
endmodule

// File: tb/tb_com_bus_arbiter.sv
// Bench for com_bus_arbiter: 8- and 4-processor instances driven together,
// directed scenarios plus random traffic against a transaction-level model.
module tb_com_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_proc = '0, req_snoop = '0;
  logic       mem_req = 1'b0;

  logic [7:0] gp8, gs8;
  logic       mg8, bb8;
  logic [3:0] gp4, gs4;
  logic       mg4, bb4;
  logic [3:0] req_proc4, req_snoop4;

  int errs = 0;
  int checks = 0;

  assign req_proc4  = req_proc[3:0];
  assign req_snoop4 = req_snoop[3:0];

  always #5 clk = ~clk;

  com_bus_arbiter #(.NUM_PROC(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .Com_Bus_Req_proc(req_proc), .Com_Bus_Req_snoop(req_snoop), .Mem_snoop_req(mem_req),
    .Com_Bus_Gnt_proc(gp8), .Com_Bus_Gnt_snoop(gs8), .Mem_snoop_gnt(mg8), .Bus_busy(bb8)
  );

  com_bus_arbiter #(.NUM_PROC(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .Com_Bus_Req_proc(req_proc4), .Com_Bus_Req_snoop(req_snoop4), .Mem_snoop_req(mem_req),
    .Com_Bus_Gnt_proc(gp4), .Com_Bus_Gnt_snoop(gs4), .Mem_snoop_gnt(mg4), .Bus_busy(bb4)
  );

  // Model: who owns the bus, who supplies data, whether memory supplies, next RR start.
  typedef struct {
    int owner;
    int sn;
    bit mem;
    int ptr;
  } mst_t;

  mst_t m8, m4;

  function automatic mst_t m_reset();
    mst_t s;
    s.owner = -1; s.sn = -1; s.mem = 1'b0; s.ptr = 0;
    return s;
  endfunction

  function automatic mst_t m_step(input mst_t s, input int n, input logic [7:0] rp,
                                  input logic [7:0] rs, input logic mr);
    mst_t t = s;
    if (s.owner < 0) begin
      t.sn = -1; t.mem = 1'b0;
      for (int k = 0; k < n; k++) begin
        int i = (s.ptr + k) % n;
        if (rp[i]) begin
          t.owner = i; t.ptr = (i + 1) % n;
          break;
        end
      end
    end else if (!rp[s.owner]) begin
      t.owner = -1; t.sn = -1; t.mem = 1'b0;
    end else if (s.sn >= 0) begin
      if (!rs[s.sn]) t.sn = -1;
    end else if (s.mem) begin
      if (!mr) t.mem = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i != s.owner && rs[i]) begin
          t.sn = i;
          break;
        end
      end
      if (t.sn < 0 && mr) t.mem = 1'b1;
    end
    return t;
  endfunction

  function automatic logic [31:0] bit_of(input int idx);
    return (idx >= 0) ? (32'd1 << idx) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("gnt_proc8",  32'(gp8), bit_of(m8.owner));
    chk("gnt_snoop8", 32'(gs8), bit_of(m8.sn));
    chk("mem_gnt8",   32'(mg8), 32'(m8.mem));
    chk("busy8",      32'(bb8), 32'(m8.owner >= 0));
    chk("gnt_proc4",  32'(gp4), bit_of(m4.owner));
    chk("gnt_snoop4", 32'(gs4), bit_of(m4.sn));
    chk("mem_gnt4",   32'(mg4), 32'(m4.mem));
    chk("busy4",      32'(bb4), 32'(m4.owner >= 0));
  endtask

  // Inputs change at posedge+1 (or negedge after reset); outputs sampled at posedge+1.
  task automatic step(input logic [7:0] rp, input logic [7:0] rs, input logic mr);
    req_proc = rp; req_snoop = rs; mem_req = mr;
    @(posedge clk);
    m8 = m_step(m8, 8, rp, rs, mr);
    m4 = m_step(m4, 4, rp, rs, mr);
    #1;
    compare_all();
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, releases on the falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m8 = m_reset();
    m4 = m_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] rp, rs;
  logic       mr;

  initial begin
    m8 = m_reset();
    m4 = m_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Reset mid-tenure (owner 2, supplier 4), then a wrap-around request.
    step(8'h04, 8'h00, 1'b0);
    chk("own2", 32'(gp8), 32'h04);
    step(8'h04, 8'h10, 1'b0);
    step(8'h04, 8'h10, 1'b0);
    chk("snoop4", 32'(gs8), 32'h10);
    do_reset();
    chk("rst_gp", 32'(gp8), 32'h0);
    chk("rst_gs", 32'(gs8), 32'h0);
    step(8'h80, 8'h00, 1'b0);
    chk("rst_wrap", 32'(gp8), 32'h80);

    // Round robin, 8 processors: all requesting, owner drops two cycles after grant.
    do_reset();
    for (int g = 0; g < 9; g++) begin
      step(8'hFF, 8'h00, 1'b0);
      chk("rr8_gnt", 32'(gp8), 32'd1 << (g % 8));
      step(8'hFF, 8'h00, 1'b0);
      step(8'hFF & ~gp8, 8'h00, 1'b0);
      chk("rr8_dead", 32'(gp8), 32'h0);
    end

    // Round robin, 4 processors.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      step(8'h0F, 8'h00, 1'b0);
      chk("rr4_gnt", 32'(gp4), 32'd1 << (g % 4));
      step(8'h0F & ~{4'h0, gp4}, 8'h00, 1'b0);
      chk("rr4_dead", 32'(gp4), 32'h0);
    end

    // Snoop masking and priority with owner 3.
    do_reset();
    step(8'h08, 8'h00, 1'b0);
    step(8'h08, 8'h0C, 1'b0);
    chk("snoop_pri", 32'(gs8), 32'h04);
    step(8'h08, 8'h08, 1'b0);
    chk("snoop_drop", 32'(gs8), 32'h00);
    step(8'h08, 8'h08, 1'b0);
    chk("snoop_mask", 32'(gs8), 32'h00);

    // Memory fallback, then a cache request waiting behind memory.
    do_reset();
    step(8'h01, 8'h00, 1'b1);
    chk("mem_idle", 32'(mg8), 32'h0);
    step(8'h01, 8'h00, 1'b1);
    chk("mem_gnt", 32'(mg8), 32'h1);
    step(8'h01, 8'h02, 1'b1);
    chk("mem_hold_gs", 32'(gs8), 32'h0);
    step(8'h01, 8'h02, 1'b0);
    chk("mem_rel", 32'(mg8), 32'h0);
    chk("mem_rel_gs", 32'(gs8), 32'h0);
    step(8'h01, 8'h02, 1'b0);
    chk("snoop_after_mem", 32'(gs8), 32'h02);

    // Owner release on the same edge a snoop request rises.
    step(8'h01, 8'h00, 1'b0);
    step(8'h00, 8'h20, 1'b0);
    chk("sim_rel_gp", 32'(gp8), 32'h0);
    chk("sim_rel_gs", 32'(gs8), 32'h0);
    chk("sim_rel_busy", 32'(bb8), 32'h0);

    // Random traffic with occasional asynchronous resets.
    rp = '0; rs = '0; mr = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 7) == 0) rp[i] = ~rp[i];
        if ($urandom_range(0, 3) == 0) rs[i] = ~rs[i];
      end
      if ($urandom_range(0, 4) == 0) mr = ~mr;
      if ($urandom_range(0, 199) == 0) do_reset();
      step(rp, rs, mr);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
